fetch_ifid_unit: RTL
====================

# fetch_ifid_unit

Fetch stage plus IF/ID pipeline register for the pipelined core. It is the consumer of the branch hazard unit's `pc_src` and `flush_ifid` outputs. It owns the PC, selects between the sequential PC and the resolved branch target, and inserts bubbles on flush. It holds state on load-use stall and freezes fetch after a halt instruction. It also keeps saturating redirect/stall counters and a sticky misaligned-target flag for debug.

## Interface
- `RESET_PC`, 64'h0, PC value loaded on reset
- `NOP_INSTR`, 32'h0000_0013, instruction word written into IF/ID on a bubble (addi x0,x0,0)
- `HALT_INSTR`, 32'h0010_0073, instruction word that stops fetch (ebreak)
- `CNT_W`, 16, width of the debug counters

Ports:
- `clk`  in  1  single clock; all state updates on rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `pc_src`  in  1  1 = redirect PC to `branch_target` (taken branch resolved in EX)
- `branch_target`  in  64  redirect address
- `flush_ifid`  in  1  1 = replace the IF/ID contents with a bubble
- `stall`  in  1  load-use stall from ID; hold PC and IF/ID
- `imem_addr`  out  64  instruction memory address, equals the PC register (combinational)
- `imem_rdata`  in  32  instruction word at `imem_addr`, combinational read, same cycle
- `ifid_pc`  out  64  PC of the instruction in IF/ID
- `ifid_instr`  out  32  instruction in IF/ID
- `ifid_valid`  out  1  IF/ID holds a real instruction
- `halted`  out  1  fetch frozen by `HALT_INSTR`
- `misalign_err`  out  1  sticky; a redirect target had bits [1:0] != 0
- `redirect_cnt`  out  CNT_W  count of accepted redirects, saturating
- `stall_cnt`  out  CNT_W  count of stall cycles honoured, saturating

## Operation
- **Reset.** Asynchronous reset, effective immediately:
  - pc = RESET_PC
  - ifid_pc = 0, ifid_instr = NOP_INSTR, ifid_valid = 0
  - state RUN, so halted = 0
  - misalign_err = 0, both counters 0
- **FSM states.** RUN and HALTED. `halted` = (state == HALTED).
- **Per-edge priority in RUN:** redirect > flush > stall > advance.
  - **Redirect** (`pc_src`=1):
    - pc = {branch_target[63:2], 2'b00}
    - IF/ID = bubble (instr NOP_INSTR, valid 0, ifid_pc unchanged)
    - redirect_cnt +1
    - if branch_target[1:0] != 0, set misalign_err
    - `stall` is ignored this edge, and stall_cnt does not increment.
  - **Flush only** (`flush_ifid`=1, `pc_src`=0):
    - IF/ID = bubble
    - pc = pc if `stall`, else pc+4
    - stall_cnt +1 if `stall`
  - **Stall only:** pc and all IF/ID fields hold; stall_cnt +1.
  - **Advance:**
    - ifid_pc = pc, ifid_instr = imem_rdata, ifid_valid = 1
    - pc = pc+4, with 64-bit modular wrap (pc = 64'hFFFF_FFFF_FFFF_FFFC → 0)
    - if imem_rdata == HALT_INSTR, next state HALTED
- **HALTED state:**
  - pc holds.
  - Every edge writes a bubble into IF/ID, except that `stall` holds IF/ID. The halt instruction itself was already captured and valid, and it drains normally.
  - `pc_src`=1 performs a normal redirect (the older branch squashes the halt) and returns to RUN.
  - `flush_ifid` alone does not leave HALTED.
- **Counters** saturate at all-ones and never wrap. misalign_err clears only on reset.

## Timing
- Fetch-to-IF/ID latency: 1 cycle. The instruction at pc appears on `ifid_*` after the next rising edge.
- **Redirect penalty.** `pc_src` is asserted in cycle N. The target instruction is in IF/ID after edge N+1. The branch hazard unit flushes ID/EX itself; this block only bubbles IF/ID.
- **Halt.** The halt word is captured at edge N and `halted` rises at edge N. From then on, imem_addr stays at the halt address + 4.
- No combinational path from inputs to `ifid_*`, `halted` or the counters. `imem_addr` depends only on the PC register.
- **Reset mid-operation** (`rst_n` low at any time) forces all reset values asynchronously, including from HALTED. The first advance happens on the first rising edge with `rst_n` high.

## Test plan
1. **Reset and sequential fetch.** Hold rst_n=0, then release; imem returns word = addr. Required:
   - pc sequence 0, 4, 8
   - at edge 1: ifid_pc=0, ifid_instr=0, ifid_valid=1
   - at edge 2: ifid_pc=4
2. **Taken branch.** At pc=0x10, pulse pc_src=1 with branch_target=0x40. Required:
   - after the edge: pc=0x40, ifid_valid=0, ifid_instr=0x00000013, redirect_cnt=1
   - after the next edge: ifid_pc=0x40, ifid_valid=1
3. **Stall, flush, and priority.** Hold stall=1 for 3 cycles at pc=0x20. Required: pc stays 0x20, IF/ID unchanged, stall_cnt=3. Then:
   - stall=1 with pc_src=1, target 0x80 → pc=0x80, stall_cnt stays 3
   - stall=1 with flush_ifid=1 → pc holds, bubble in IF/ID
4. **Misaligned target.** pc_src=1, branch_target=0x102. Required: pc=0x100, misalign_err=1. A later aligned redirect leaves misalign_err=1.
5. **Halt.** imem returns 0x00100073 at pc=0x30. Required:
   - after capture: halted=1, ifid_instr=0x00100073, ifid_valid=1, pc=0x34
   - next edge: bubble in IF/ID, pc stays 0x34
   - pc_src=1, target=0x0 → halted=0, pc=0
6. **Saturation, wrap, and async reset.** Preload via long stall so stall_cnt reaches 16'hFFFF, then one more stall cycle → stays 16'hFFFF. Redirect to 0xFFFF_FFFF_FFFF_FFFC, advance → pc=0. Drop rst_n between clock edges → all outputs at reset values immediately.

Source files
------------

// File: rtl/fetch_ifid_unit.sv
// Fetch stage and IF/ID pipeline register.
// Owns the PC and picks the next fetch address: a redirect to a resolved
// branch target, the sequential PC, or a hold while ID stalls. IF/ID is
// loaded with the fetched word, or with a bubble on a flush or redirect.
// A fetched halt word freezes fetch until a redirect arrives. Saturating
// redirect/stall counters and a sticky misaligned-target flag support debug.
module fetch_ifid_unit #(
  parameter logic [63:0] RESET_PC   = 64'h0,
  parameter logic [31:0] NOP_INSTR  = 32'h0000_0013,
  parameter logic [31:0] HALT_INSTR = 32'h0010_0073,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pc_src,
  input  logic [63:0]      branch_target,
  input  logic             flush_ifid,
  input  logic             stall,
  output logic [63:0]      imem_addr,
  input  logic [31:0]      imem_rdata,
  output logic [63:0]      ifid_pc,
  output logic [31:0]      ifid_instr,
  output logic             ifid_valid,
  output logic             halted,
  output logic             misalign_err,
  output logic [CNT_W-1:0] redirect_cnt,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_HALTED = 1'b1
  } state_e;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [63:0]      PC_STEP = 64'd4;

  state_e           state_q, state_d;
  logic [63:0]      pc_q, pc_d;
  logic [63:0]      ifid_pc_q, ifid_pc_d;
  logic [31:0]      ifid_instr_q, ifid_instr_d;
  logic             ifid_valid_q, ifid_valid_d;
  logic             misalign_q, misalign_d;
  logic [CNT_W-1:0] redirect_cnt_q, redirect_cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  logic [63:0]      pc_seq;
  logic [63:0]      pc_redirect;
  logic             target_misaligned;
  logic             is_halt_word;

  // Datapath helpers shared by the next-state logic.
  always_comb begin
    pc_seq            = pc_q + PC_STEP;  // 64-bit modular wrap is intended
    pc_redirect       = {branch_target[63:2], 2'b00};
    target_misaligned = (branch_target[1:0] != 2'b00);
    is_halt_word      = (imem_rdata == HALT_INSTR);
  end

  // Next-state logic: FSM, PC, IF/ID and debug state.
  // Priority: redirect > flush > stall > advance. HALTED only leaves on redirect.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path leaves a
    // variable unassigned and no latch is inferred.
    state_d        = state_q;
    pc_d           = pc_q;
    ifid_pc_d      = ifid_pc_q;
    ifid_instr_d   = ifid_instr_q;
    ifid_valid_d   = ifid_valid_q;
    misalign_d     = misalign_q;
    redirect_cnt_d = redirect_cnt_q;
    stall_cnt_d    = stall_cnt_q;

    if (pc_src) begin
      // Redirect wins over everything, including stall; it also squashes a halt.
      state_d        = ST_RUN;
      pc_d           = pc_redirect;
      ifid_instr_d   = NOP_INSTR;
      ifid_valid_d   = 1'b0;
      redirect_cnt_d = (redirect_cnt_q == CNT_MAX) ? redirect_cnt_q
                                                   : redirect_cnt_q + CNT_ONE;
      if (target_misaligned) begin
        misalign_d = 1'b1;
      end
    end else begin
      // A stall not overridden by a redirect is always honoured and counted.
      if (stall) begin
        stall_cnt_d = (stall_cnt_q == CNT_MAX) ? stall_cnt_q
                                               : stall_cnt_q + CNT_ONE;
      end

      unique case (state_q)
        ST_RUN: begin
          if (flush_ifid) begin
            ifid_instr_d = NOP_INSTR;
            ifid_valid_d = 1'b0;
            if (!stall) begin
              pc_d = pc_seq;
            end
          end else if (!stall) begin
            ifid_pc_d    = pc_q;
            ifid_instr_d = imem_rdata;
            ifid_valid_d = 1'b1;
            pc_d         = pc_seq;
            if (is_halt_word) begin
              state_d = ST_HALTED;
            end
          end
        end

        ST_HALTED: begin
          // PC is frozen; IF/ID drains to bubbles unless ID holds it.
          if (flush_ifid || !stall) begin
            ifid_instr_d = NOP_INSTR;
            ifid_valid_d = 1'b0;
          end
        end

        default: begin
          state_d = ST_RUN;
        end
      endcase
    end
  end

  // State register with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (!rst_n) begin
      state_q        <= ST_RUN;
      pc_q           <= RESET_PC;
      ifid_pc_q      <= 64'h0;
      ifid_instr_q   <= NOP_INSTR;
      ifid_valid_q   <= 1'b0;
      misalign_q     <= 1'b0;
      redirect_cnt_q <= '0;
      stall_cnt_q    <= '0;
    end else begin
      state_q        <= state_d;
      pc_q           <= pc_d;
      ifid_pc_q      <= ifid_pc_d;
      ifid_instr_q   <= ifid_instr_d;
      ifid_valid_q   <= ifid_valid_d;
      misalign_q     <= misalign_d;
      redirect_cnt_q <= redirect_cnt_d;
      stall_cnt_q    <= stall_cnt_d;
    end
  end

  // Outputs come straight from registers; no input reaches them combinationally.
  always_comb begin
    imem_addr    = pc_q;
    ifid_pc      = ifid_pc_q;
    ifid_instr   = ifid_instr_q;
    ifid_valid   = ifid_valid_q;
    halted       = (state_q == ST_HALTED);
    misalign_err = misalign_q;
    redirect_cnt = redirect_cnt_q;
    stall_cnt    = stall_cnt_q;
  end

endmodule
